// File: rtl/match_counter_if.sv
// Control/status bundle for match_counter: start/stop/target in, count/busy/done out.
// prescale_i exists only when MATCH_COUNTER_PRESCALE_EN is defined.
interface match_counter_if #(
    parameter int DATA_WIDTH  = 13
`ifdef MATCH_COUNTER_PRESCALE_EN
    ,
    parameter int PRESC_WIDTH = 8
`endif
);
    logic                   start_i;
    logic                   stop_i;
    logic [DATA_WIDTH-1:0]  target_i;
    logic                   auto_reload_i;
`ifdef MATCH_COUNTER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] prescale_i;
`endif
    logic [DATA_WIDTH-1:0]  count_o;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        output start_i, stop_i, target_i, auto_reload_i,
`ifdef MATCH_COUNTER_PRESCALE_EN
        output prescale_i,
`endif
        input  count_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, target_i, auto_reload_i,
`ifdef MATCH_COUNTER_PRESCALE_EN
        input  prescale_i,
`endif
        output count_o, busy_o, done_o
    );
endinterface

// File: rtl/match_counter.sv
// Programmable up-counter with terminal-match done pulse, one-shot or auto-reload.
// Define MATCH_COUNTER_PRESCALE_EN to add a tick prescaler (prescale_i on the interface).
module match_counter #(
    parameter int DATA_WIDTH  = 13
`ifdef MATCH_COUNTER_PRESCALE_EN
    ,
    parameter int PRESC_WIDTH = 8
`endif
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    match_counter_if.slave     bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   count_q;
    logic [DATA_WIDTH-1:0]   target_q;
    logic                    reload_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    tick;
    logic                    match;

`ifdef MATCH_COUNTER_PRESCALE_EN
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESC_WIDTH-1:0]  presc_q;
    logic [PRESC_WIDTH-1:0]  presc_cnt_q;

    assign tick = (presc_cnt_q == presc_q);
`else
    assign tick = 1'b1;
`endif

    // count_q never passes target_q, so the increment below cannot wrap.
    assign match = (count_q == target_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            target_q    <= '0;
            reload_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MATCH_COUNTER_PRESCALE_EN
            presc_q     <= '0;
            presc_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values;
            // the default below makes done_q a single-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.stop_i) begin
                        target_q    <= bus.target_i;
                        reload_q    <= bus.auto_reload_i;
                        count_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
`ifdef MATCH_COUNTER_PRESCALE_EN
                        presc_q     <= bus.prescale_i;
                        presc_cnt_q <= '0;
`endif
                    end
                end
                RUN: begin
                    if (bus.stop_i) begin
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifdef MATCH_COUNTER_PRESCALE_EN
                        presc_cnt_q <= '0;
`endif
                    end else if (tick) begin
`ifdef MATCH_COUNTER_PRESCALE_EN
                        presc_cnt_q <= '0;
`endif
                        if (!match) begin
                            count_q <= count_q + CNT_ONE;
                        end else begin
                            done_q <= 1'b1;
                            if (reload_q) begin
                                count_q <= '0;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
`ifdef MATCH_COUNTER_PRESCALE_EN
                    else begin
                        presc_cnt_q <= presc_cnt_q + PRESC_ONE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count_o = count_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_match_counter.sv
// Directed bench for match_counter; each task drives a scenario and checks
// {count_o, busy_o, done_o} one time unit after every rising edge.
module tb_match_counter;
    localparam int DW = 13;
`ifdef MATCH_COUNTER_PRESCALE_EN
    localparam int PW = 8;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef MATCH_COUNTER_PRESCALE_EN
    match_counter_if #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) bus ();
    match_counter #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus));
`else
    match_counter_if #(.DATA_WIDTH(DW)) bus ();
    match_counter #(.DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus));
`endif

    logic [DW+1:0] obs;
    assign obs = {bus.count_o, bus.busy_o, bus.done_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i       = 1'b0;
        bus.stop_i        = 1'b0;
        bus.target_i      = '0;
        bus.auto_reload_i = 1'b0;
`ifdef MATCH_COUNTER_PRESCALE_EN
        bus.prescale_i    = '0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) step();
        checks++;
        if (obs !== {DW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held got cnt=%0d busy=%b done=%b want cnt=0 busy=0 done=0",
                     obs[DW+1:2], obs[1], obs[0]);
        end
        #2 rstn = 1'b1;
        step();
        checks++;
        if (obs !== {DW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_released got cnt=%0d busy=%b done=%b want cnt=0 busy=0 done=0",
                     obs[DW+1:2], obs[1], obs[0]);
        end
    endtask

    // target=3 one-shot: count 0,1,2,3, done after E4, then hold at 3 in IDLE.
    task automatic test_one_shot();
        logic [DW-1:0] exp_cnt;
        logic          exp_busy, exp_done;
        idle_inputs();
        bus.target_i = DW'(3);
        bus.start_i  = 1'b1;
        for (int n = 0; n <= 6; n++) begin
            step();
            bus.start_i = 1'b0;
            exp_cnt  = (n <= 3) ? DW'(n) : DW'(3);
            exp_busy = (n <= 3);
            exp_done = (n == 4);
            checks++;
            if (obs !== {exp_cnt, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL one_shot E%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                         n, obs[DW+1:2], obs[1], obs[0], exp_cnt, exp_busy, exp_done);
            end
        end
    endtask

    // target=0 with reload: done every edge from E1; stop on a match edge wins.
    task automatic test_zero_reload();
        idle_inputs();
        bus.target_i      = '0;
        bus.auto_reload_i = 1'b1;
        bus.start_i       = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            if (n == 5) bus.stop_i = 1'b1;
            step();
            bus.start_i = 1'b0;
            bus.stop_i  = 1'b0;
            checks++;
            if (obs !== {DW'(0), (n != 5), (n >= 1 && n <= 4)}) begin
                errors++;
                $display("FAIL zero_reload E%0d got cnt=%0d busy=%b done=%b want cnt=0 busy=%b done=%b",
                         n, obs[DW+1:2], obs[1], obs[0], (n != 5), (n >= 1 && n <= 4));
            end
        end
    endtask

    // target=5 with reload: done at E6, E12, E18 and count back to 0 each time.
    task automatic test_reload_period();
        logic [DW-1:0] exp_cnt;
        idle_inputs();
        bus.target_i      = DW'(5);
        bus.auto_reload_i = 1'b1;
        bus.start_i       = 1'b1;
        for (int n = 0; n <= 19; n++) begin
            if (n == 19) bus.stop_i = 1'b1;
            step();
            bus.start_i = 1'b0;
            bus.stop_i  = 1'b0;
            exp_cnt = (n == 19) ? DW'(0) : DW'(n % 6);
            checks++;
            if (obs !== {exp_cnt, (n != 19), (n != 0 && n != 19 && n % 6 == 0)}) begin
                errors++;
                $display("FAIL reload_period E%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                         n, obs[DW+1:2], obs[1], obs[0], exp_cnt, (n != 19),
                         (n != 0 && n != 19 && n % 6 == 0));
            end
        end
    endtask

    // Stop once count reaches 2; then start+stop together in IDLE loads nothing.
    task automatic test_stop();
        logic [DW-1:0] exp_cnt;
        idle_inputs();
        bus.target_i = DW'(4);
        bus.start_i  = 1'b1;
        for (int n = 0; n <= 6; n++) begin
            if (n == 3) bus.stop_i = 1'b1;
            if (n == 5) begin
                bus.start_i  = 1'b1;
                bus.stop_i   = 1'b1;
                bus.target_i = DW'(7);
            end
            step();
            bus.start_i = 1'b0;
            bus.stop_i  = 1'b0;
            exp_cnt = (n <= 2) ? DW'(n) : DW'(2);
            checks++;
            if (obs !== {exp_cnt, (n <= 2), 1'b0}) begin
                errors++;
                $display("FAIL stop E%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=0",
                         n, obs[DW+1:2], obs[1], obs[0], exp_cnt, (n <= 2));
            end
        end
    endtask

    // target=10; target_i/auto_reload_i/start_i changed mid-run must be ignored.
    task automatic test_ignore_in_run();
        logic [DW-1:0] exp_cnt;
        idle_inputs();
        bus.target_i = DW'(10);
        bus.start_i  = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            if (n == 3) begin
                bus.target_i      = DW'(2);
                bus.auto_reload_i = 1'b1;
                bus.start_i       = 1'b1;
            end
            step();
            bus.start_i = 1'b0;
            exp_cnt = (n <= 10) ? DW'(n) : DW'(10);
            checks++;
            if (obs !== {exp_cnt, (n <= 10), (n == 11)}) begin
                errors++;
                $display("FAIL ignore_in_run E%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                         n, obs[DW+1:2], obs[1], obs[0], exp_cnt, (n <= 10), (n == 11));
            end
        end
        idle_inputs();
    endtask

    // Reset asserted between edges mid-run clears outputs at once.
    task automatic test_async_reset();
        idle_inputs();
        bus.target_i      = DW'(7);
        bus.auto_reload_i = 1'b1;
        bus.start_i       = 1'b1;
        step();
        bus.start_i = 1'b0;
        repeat (5) step();
        checks++;
        if (obs !== {DW'(5), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL areset_pre got cnt=%0d busy=%b done=%b want cnt=5 busy=1 done=0",
                     obs[DW+1:2], obs[1], obs[0]);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (obs !== {DW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate got cnt=%0d busy=%b done=%b want cnt=0 busy=0 done=0",
                     obs[DW+1:2], obs[1], obs[0]);
        end
        step();
        #2 rstn = 1'b1;
        repeat (3) step();
        checks++;
        if (obs !== {DW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL areset_after got cnt=%0d busy=%b done=%b want cnt=0 busy=0 done=0",
                     obs[DW+1:2], obs[1], obs[0]);
        end
    endtask

`ifdef MATCH_COUNTER_PRESCALE_EN
    // target=2, prescale=3: count steps every 4 edges, done after E12.
    task automatic test_prescale();
        logic [DW-1:0] exp_cnt;
        idle_inputs();
        bus.target_i   = DW'(2);
        bus.prescale_i = PW'(3);
        bus.start_i    = 1'b1;
        for (int n = 0; n <= 13; n++) begin
            step();
            bus.start_i = 1'b0;
            exp_cnt = (n >= 12) ? DW'(2) : DW'(n / 4);
            checks++;
            if (obs !== {exp_cnt, (n < 12), (n == 12)}) begin
                errors++;
                $display("FAIL prescale E%0d got cnt=%0d busy=%b done=%b want cnt=%0d busy=%b done=%b",
                         n, obs[DW+1:2], obs[1], obs[0], exp_cnt, (n < 12), (n == 12));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_zero_reload();
        test_reload_period();
        test_stop();
        test_ignore_in_run();
        test_async_reset();
`ifdef MATCH_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
